shift_register_sequencer: RTL and testbench

//  Control sequencer for one 4-bit universal ShiftRegister (CLK, D, S, OE, Q).

---
 rtl/shift_register_sequencer.sv | 112 +++++++++++
 tb/tb_shift_register_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/shift_register_sequencer.sv
// Sequencer for a 4-bit universal shift register: it loads a word, shifts it a
// programmed number of times, reads Q back and returns it over valid/ready.
module shift_register_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  input  logic             dir,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] sr_d,
  output logic [1:0]       sr_s,
  output logic             sr_oe,
  input  logic [WIDTH-1:0] sr_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_OUTPUT,
    S_WAIT
  } state_t;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_RIGHT = 2'b01;
  localparam logic [1:0] SEL_LEFT  = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  state_t           state;
  logic [CNT_W-1:0] rem;
  logic             dirReg;

  // Every output is set together with the state it belongs to, so the shift
  // register sees a clean select for each state with no input-to-output path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      sr_s      <= SEL_HOLD;
      sr_oe     <= 1'b0;
      sr_d      <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      busy      <= 1'b0;
      rem       <= '0;
      dirReg    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            sr_d     <= din;
            dirReg   <= dir;
            rem      <= count;
            sr_s     <= SEL_LOAD;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (rem == '0) begin
            sr_s  <= SEL_HOLD;
            sr_oe <= 1'b1;
            state <= S_OUTPUT;
          end else begin
            sr_s  <= dirReg ? SEL_LEFT : SEL_RIGHT;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // rem is at least 1 here, so the decrement cannot wrap.
          rem <= rem - 1'b1;
          if (rem == CNT_W'(1)) begin
            sr_s  <= SEL_HOLD;
            sr_oe <= 1'b1;
            state <= S_OUTPUT;
          end
        end
        S_OUTPUT: begin
          result    <= sr_q;
          out_valid <= 1'b1;
          sr_oe     <= 1'b0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state    <= S_IDLE;
          sr_s     <= SEL_HOLD;
          sr_oe    <= 1'b0;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_register_sequencer.sv
// Bench for shift_register_sequencer driving a behavioural 4-bit universal
// shift register; expected results are queued at accept and checked on output.
module tb_shift_register_sequencer;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] din;
  logic       dir;
  logic [2:0] count;
  logic [3:0] sr_d;
  logic [1:0] sr_s;
  logic       sr_oe;
  logic [3:0] sr_q;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] result;
  logic       busy;

  typedef struct {
    logic [3:0] din;
    logic       dir;
    logic [2:0] count;
    logic [3:0] expResult;
  } job_t;

  job_t jobQueue[$];
  int   checkCount = 0;
  int   failCount  = 0;
  logic [3:0] srReg;

  shift_register_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .dir(dir), .count(count), .sr_d(sr_d), .sr_s(sr_s),
    .sr_oe(sr_oe), .sr_q(sr_q), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Universal shift register: 00 hold, 01 right, 10 left, 11 load, zero fill.
  always_ff @(posedge clk) begin
    case (sr_s)
      2'b01:   srReg <= {1'b0, srReg[3:1]};
      2'b10:   srReg <= {srReg[2:0], 1'b0};
      2'b11:   srReg <= sr_d;
      default: srReg <= srReg;
    endcase
  end
  assign sr_q = sr_oe ? srReg : 4'bxxxx;

  function automatic logic [3:0] modelShift(logic [3:0] d, logic dr, logic [2:0] c);
    logic [3:0] r = d;
    for (int i = 0; i < c; i++) r = dr ? {r[2:0], 1'b0} : {1'b0, r[3:1]};
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Presents a job in the current cycle and queues its expected result.
  task automatic applyStimulus(input logic [3:0] d, input logic dr, input logic [2:0] c);
    job_t j;
    j.din = d; j.dir = dr; j.count = c; j.expResult = modelShift(d, dr, c);
    jobQueue.push_back(j);
    din = d; dir = dr; count = c; in_valid = 1'b1;
  endtask

  // Follows the front job from its accept edge through to release of the result.
  task automatic followJob(input int hold, input bit keepValid);
    job_t j = jobQueue[0];
    @(posedge clk); #1;
    if (!keepValid) in_valid = 1'b0;
    din = 4'($urandom); dir = 1'($urandom); count = 3'($urandom);
    checkOutput("load_s", 8'(sr_s), 8'd3);
    checkOutput("load_oe", 8'(sr_oe), 8'd0);
    checkOutput("load_busy", 8'(busy), 8'd1);
    checkOutput("load_in_ready", 8'(in_ready), 8'd0);
    for (int i = 0; i < j.count; i++) begin
      @(posedge clk); #1;
      checkOutput("shift_s", 8'(sr_s), j.dir ? 8'd2 : 8'd1);
      checkOutput("shift_oe", 8'(sr_oe), 8'd0);
      checkOutput("shift_busy", 8'(busy), 8'd1);
      checkOutput("shift_out_valid", 8'(out_valid), 8'd0);
    end
    @(posedge clk); #1;
    checkOutput("output_s", 8'(sr_s), 8'd0);
    checkOutput("output_oe", 8'(sr_oe), 8'd1);
    checkOutput("output_out_valid", 8'(out_valid), 8'd0);
    @(posedge clk); #1;
    checkOutput("latency_out_valid", 8'(out_valid), 8'd1);
    checkOutput("wait_oe", 8'(sr_oe), 8'd0);
    checkOutput("wait_busy", 8'(busy), 8'd1);
    j = jobQueue.pop_front();
    checkOutput("result", 8'(result), 8'(j.expResult));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      checkOutput("bp_out_valid", 8'(out_valid), 8'd1);
      checkOutput("bp_result", 8'(result), 8'(j.expResult));
      checkOutput("bp_in_ready", 8'(in_ready), 8'd0);
      checkOutput("bp_s", 8'(sr_s), 8'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("release_out_valid", 8'(out_valid), 8'd0);
    checkOutput("release_in_ready", 8'(in_ready), 8'd1);
    checkOutput("release_busy", 8'(busy), 8'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; din = '0; dir = 1'b0; count = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 8'(in_ready), 8'd1);
    checkOutput("rst_s", 8'(sr_s), 8'd0);
    checkOutput("rst_oe", 8'(sr_oe), 8'd0);
    checkOutput("rst_d", 8'(sr_d), 8'd0);
    checkOutput("rst_out_valid", 8'(out_valid), 8'd0);
    checkOutput("rst_result", 8'(result), 8'd0);
    checkOutput("rst_busy", 8'(busy), 8'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a shift sequence aborts the job.
    applyStimulus(4'b1111, 1'b0, 3'd5);
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("abort_pre_s", 8'(sr_s), 8'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_s", 8'(sr_s), 8'd0);
    checkOutput("abort_oe", 8'(sr_oe), 8'd0);
    checkOutput("abort_busy", 8'(busy), 8'd0);
    checkOutput("abort_in_ready", 8'(in_ready), 8'd1);
    checkOutput("abort_out_valid", 8'(out_valid), 8'd0);
    void'(jobQueue.pop_front());
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("post_abort_out_valid", 8'(out_valid), 8'd0);

    applyStimulus(4'b0101, 1'b0, 3'd1); followJob(0, 1'b0);
    applyStimulus(4'b0101, 1'b1, 3'd2); followJob(0, 1'b0);
    applyStimulus(4'b1011, 1'b0, 3'd0); followJob(0, 1'b0);

    // Backpressure with a second request already waiting at the input.
    applyStimulus(4'b0011, 1'b1, 3'd1); followJob(5, 1'b1);
    applyStimulus(4'b1001, 1'b0, 3'd2); followJob(0, 1'b0);

    applyStimulus(4'b1111, 1'b0, 3'd7); followJob(0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      applyStimulus(4'($urandom), 1'($urandom), 3'($urandom));
      followJob(int'($urandom_range(0, 2)), 1'b0);
    end

    checkOutput("queue_empty", 8'(jobQueue.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
